// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter sharing one APB master command port between NUM_REQ requesters.
// Optional WAIT watchdog and ERR port are compiled in with the macro APB_ARB_TIMEOUT_EN.
module apb_req_arbiter #(
    parameter int DATA_WIDTH      = 32,
    parameter int MAIN_ADDR_WIDTH = 32,
    parameter int NUM_REQ         = 4,
    parameter int TIMEOUT_CYCLES  = 255
) (
    input  logic                                    PCLK,
    input  logic                                    PRESET,
    input  logic [NUM_REQ-1:0]                      REQ,
    input  logic [NUM_REQ*MAIN_ADDR_WIDTH-1:0]      REQ_ADDR,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]           REQ_WDATA,
    input  logic [NUM_REQ*(DATA_WIDTH/8)-1:0]       REQ_STRB,
    input  logic [NUM_REQ-1:0]                      REQ_WRITE,
    output logic [NUM_REQ-1:0]                      DONE,
`ifdef APB_ARB_TIMEOUT_EN
    output logic [NUM_REQ-1:0]                      ERR,
`endif
    output logic [DATA_WIDTH-1:0]                   RDATA,
    output logic [$clog2(NUM_REQ)-1:0]              GNT_ID,
    output logic                                    BUSY,
    output logic                                    M_TRANSFER,
    output logic [MAIN_ADDR_WIDTH-1:0]              M_ADDR,
    output logic [DATA_WIDTH-1:0]                   M_WDATA,
    output logic [DATA_WIDTH/8-1:0]                 M_STRB,
    output logic                                    M_WRITE,
    input  logic                                    M_READY,
    input  logic [DATA_WIDTH-1:0]                   M_RDATA
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int ID_WIDTH   = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || (DATA_WIDTH % 8) != 0 ||
        TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_params
        $error("apb_req_arbiter: unsupported parameter set");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_e;

    state_e                       state_q, state_d;
    logic [ID_WIDTH-1:0]          ptr_q, ptr_d;
    logic [ID_WIDTH-1:0]          gnt_q, gnt_d;
    logic                         busy_q, busy_d;
    logic                         xfer_q, xfer_d;
    logic [MAIN_ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]        wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0]        strb_q, strb_d;
    logic                         write_q, write_d;
    logic [DATA_WIDTH-1:0]        rdata_q, rdata_d;
    logic [NUM_REQ-1:0]           done_q, done_d;

`ifdef APB_ARB_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES < 256) ? 8 : 16;
    logic [TO_W-1:0]              cnt_q, cnt_d;
    logic [NUM_REQ-1:0]           err_q, err_d;
`endif

    // Round-robin search starting just after the last grantee.
    logic                         found;
    logic [ID_WIDTH-1:0]          winner;
    logic [ID_WIDTH-1:0]          cand;

    always_comb begin
        // NOTE: every variable assigned here gets a default first, so no path can infer a latch.
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = ID_WIDTH'((int'(ptr_q) + k) % NUM_REQ);
            if (!found && REQ[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        busy_d  = busy_q;
        xfer_d  = xfer_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        strb_d  = strb_q;
        write_d = write_q;
        rdata_d = rdata_q;
        done_d  = '0;
`ifdef APB_ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = '0;
`endif

        case (state_q)
            S_IDLE: begin
                if (found) begin
                    gnt_d   = winner;
                    ptr_d   = winner;
                    addr_d  = REQ_ADDR[int'(winner)*MAIN_ADDR_WIDTH +: MAIN_ADDR_WIDTH];
                    wdata_d = REQ_WDATA[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
                    strb_d  = REQ_STRB[int'(winner)*STRB_WIDTH +: STRB_WIDTH];
                    write_d = REQ_WRITE[winner];
                    busy_d  = 1'b1;
                    state_d = S_ISSUE;
                end
            end

            S_ISSUE: begin
                xfer_d  = 1'b1;
                state_d = S_WAIT;
`ifdef APB_ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end

            S_WAIT: begin
                // A READY on the timeout edge still counts as a normal completion.
                if (M_READY) begin
                    if (!write_q) begin
                        rdata_d = M_RDATA;
                    end
                    xfer_d         = 1'b0;
                    done_d[gnt_q]  = 1'b1;
                    state_d        = S_DONE;
                end
`ifdef APB_ARB_TIMEOUT_EN
                else if (cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    xfer_d         = 1'b0;
                    rdata_d        = '0;
                    done_d[gnt_q]  = 1'b1;
                    err_d[gnt_q]   = 1'b1;
                    state_d        = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end

            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q <= S_IDLE;
            ptr_q   <= ID_WIDTH'(NUM_REQ - 1);
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            xfer_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            strb_q  <= '0;
            write_q <= 1'b0;
            rdata_q <= '0;
            done_q  <= '0;
`ifdef APB_ARB_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            busy_q  <= busy_d;
            xfer_q  <= xfer_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            strb_q  <= strb_d;
            write_q <= write_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
`ifdef APB_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    assign DONE       = done_q;
    assign RDATA      = rdata_q;
    assign GNT_ID     = gnt_q;
    assign BUSY       = busy_q;
    assign M_TRANSFER = xfer_q;
    assign M_ADDR     = addr_q;
    assign M_WDATA    = wdata_q;
    assign M_STRB     = strb_q;
    assign M_WRITE    = write_q;
`ifdef APB_ARB_TIMEOUT_EN
    assign ERR        = err_q;
`endif

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Self-checking bench for apb_req_arbiter: cycle-vector table plus directed corner sequences.
module tb_apb_req_arbiter;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int NR = 4;

    logic            pclk;
    logic            preset;
    logic [NR-1:0]   req;
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_wdata;
    logic [NR*4-1:0] req_strb;
    logic [NR-1:0]   req_write;
    logic [NR-1:0]   done;
    logic [DW-1:0]   rdata;
    logic [1:0]      gnt_id;
    logic            busy;
    logic            m_transfer;
    logic [AW-1:0]   m_addr;
    logic [DW-1:0]   m_wdata;
    logic [3:0]      m_strb;
    logic            m_write;
    logic            m_ready;
    logic [DW-1:0]   m_rdata;
`ifdef APB_ARB_TIMEOUT_EN
    logic [NR-1:0]   err;
`endif

    localparam logic [31:0] C_ADDR  [4] = '{32'h0000_0004, 32'h0000_0100, 32'h0000_0010, 32'h0000_0300};
    localparam logic [31:0] C_WDATA [4] = '{32'hA1A1_A1A1, 32'hB2B2_B2B2, 32'h1234_5678, 32'hD4D4_D4D4};
    localparam logic [3:0]  C_STRB  [4] = '{4'hF, 4'h3, 4'h5, 4'hC};
    localparam logic [3:0]  C_WRITE     = 4'b0100;

    logic [31:0] a_addr [4];

    int n_checks = 0;
    int n_errors = 0;

    apb_req_arbiter #(
        .DATA_WIDTH      (DW),
        .MAIN_ADDR_WIDTH (AW),
        .NUM_REQ         (NR),
        .TIMEOUT_CYCLES  (8)
    ) dut (
        .PCLK       (pclk),
        .PRESET     (preset),
        .REQ        (req),
        .REQ_ADDR   (req_addr),
        .REQ_WDATA  (req_wdata),
        .REQ_STRB   (req_strb),
        .REQ_WRITE  (req_write),
        .DONE       (done),
`ifdef APB_ARB_TIMEOUT_EN
        .ERR        (err),
`endif
        .RDATA      (rdata),
        .GNT_ID     (gnt_id),
        .BUSY       (busy),
        .M_TRANSFER (m_transfer),
        .M_ADDR     (m_addr),
        .M_WDATA    (m_wdata),
        .M_STRB     (m_strb),
        .M_WRITE    (m_write),
        .M_READY    (m_ready),
        .M_RDATA    (m_rdata)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    always_comb begin
        req_addr  = '0;
        req_wdata = '0;
        req_strb  = '0;
        for (int i = 0; i < NR; i++) begin
            req_addr[i*AW +: AW]  = a_addr[i];
            req_wdata[i*DW +: DW] = C_WDATA[i];
            req_strb[i*4 +: 4]    = C_STRB[i];
        end
    end
    assign req_write = C_WRITE;

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic        rdy;
        logic [31:0] mrd;
        logic [3:0]  e_done;
        logic        e_busy;
        logic [1:0]  e_gnt;
        logic        e_xfer;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [3:0]  e_strb;
        logic        e_write;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t vecs[$];

    // e_cmd = 1: M_* expected to carry requester e_gnt's command; 0: M_* expected cleared.
    function automatic vec_t mk(input logic rst, input logic [3:0] rq, input logic rdy,
                                input logic [31:0] mrd, input logic [3:0] e_done,
                                input logic e_busy, input logic [1:0] e_gnt, input logic e_xfer,
                                input logic e_cmd, input logic [31:0] e_rdata);
        vec_t v;
        v.rst     = rst;
        v.req     = rq;
        v.rdy     = rdy;
        v.mrd     = mrd;
        v.e_done  = e_done;
        v.e_busy  = e_busy;
        v.e_gnt   = e_gnt;
        v.e_xfer  = e_xfer;
        v.e_addr  = e_cmd ? C_ADDR[e_gnt]  : 32'h0;
        v.e_wdata = e_cmd ? C_WDATA[e_gnt] : 32'h0;
        v.e_strb  = e_cmd ? C_STRB[e_gnt]  : 4'h0;
        v.e_write = e_cmd ? C_WRITE[e_gnt] : 1'b0;
        v.e_rdata = e_rdata;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_row(input string tag, input vec_t v);
        check({tag, ".done"},  32'(done),       32'(v.e_done));
        check({tag, ".busy"},  32'(busy),       32'(v.e_busy));
        check({tag, ".gnt"},   32'(gnt_id),     32'(v.e_gnt));
        check({tag, ".xfer"},  32'(m_transfer), 32'(v.e_xfer));
        check({tag, ".addr"},  m_addr,          v.e_addr);
        check({tag, ".wdata"}, m_wdata,         v.e_wdata);
        check({tag, ".strb"},  32'(m_strb),     32'(v.e_strb));
        check({tag, ".write"}, 32'(m_write),    32'(v.e_write));
        check({tag, ".rdata"}, rdata,           v.e_rdata);
    endtask

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] exp_rd;
        logic [31:0] mrd;
        int          id;
        vec_t        v;

        preset  = 1'b1;
        req     = '0;
        m_ready = 1'b0;
        m_rdata = '0;
        for (int i = 0; i < NR; i++) a_addr[i] = C_ADDR[i];

        // Reset, then single read with READY already high in IDLE and ISSUE (must be ignored).
        vecs.push_back(mk(1'b1, 4'h0, 1'b0, 32'h0,         4'h0, 1'b0, 2'd0, 1'b0, 1'b0, 32'h0));
        vecs.push_back(mk(1'b0, 4'h1, 1'b1, 32'h1111_1111, 4'h0, 1'b1, 2'd0, 1'b0, 1'b1, 32'h0));
        vecs.push_back(mk(1'b0, 4'h1, 1'b1, 32'h2222_2222, 4'h0, 1'b1, 2'd0, 1'b1, 1'b1, 32'h0));
        vecs.push_back(mk(1'b0, 4'h1, 1'b0, 32'h0,         4'h0, 1'b1, 2'd0, 1'b1, 1'b1, 32'h0));
        vecs.push_back(mk(1'b0, 4'h1, 1'b1, 32'hDEAD_BEEF, 4'h1, 1'b1, 2'd0, 1'b0, 1'b1, 32'hDEAD_BEEF));
        vecs.push_back(mk(1'b0, 4'h0, 1'b0, 32'h0,         4'h0, 1'b0, 2'd0, 1'b0, 1'b1, 32'hDEAD_BEEF));
        // Write pass-through from requester 2; RDATA must keep the last read value.
        vecs.push_back(mk(1'b0, 4'h4, 1'b0, 32'h0,         4'h0, 1'b1, 2'd2, 1'b0, 1'b1, 32'hDEAD_BEEF));
        vecs.push_back(mk(1'b0, 4'h4, 1'b0, 32'h0,         4'h0, 1'b1, 2'd2, 1'b1, 1'b1, 32'hDEAD_BEEF));
        vecs.push_back(mk(1'b0, 4'h4, 1'b1, 32'hCAFE_F00D, 4'h4, 1'b1, 2'd2, 1'b0, 1'b1, 32'hDEAD_BEEF));
        vecs.push_back(mk(1'b0, 4'h0, 1'b0, 32'h0,         4'h0, 1'b0, 2'd2, 1'b0, 1'b1, 32'hDEAD_BEEF));
        // Fairness from reset: all requesting, READY held high, order 0,1,2,3,0.
        vecs.push_back(mk(1'b1, 4'hF, 1'b1, 32'h0,         4'h0, 1'b0, 2'd0, 1'b0, 1'b0, 32'h0));
        exp_rd = 32'h0;
        for (int g = 0; g < 5; g++) begin
            id  = g % 4;
            mrd = 32'hA000_0000 | 32'(id);
            vecs.push_back(mk(1'b0, 4'hF, 1'b1, mrd, 4'h0, 1'b1, 2'(id), 1'b0, 1'b1, exp_rd));
            vecs.push_back(mk(1'b0, 4'hF, 1'b1, mrd, 4'h0, 1'b1, 2'(id), 1'b1, 1'b1, exp_rd));
            if (!C_WRITE[id]) exp_rd = mrd;
            vecs.push_back(mk(1'b0, 4'hF, 1'b1, mrd, 4'(1 << id), 1'b1, 2'(id), 1'b0, 1'b1, exp_rd));
            vecs.push_back(mk(1'b0, 4'hF, 1'b1, mrd, 4'h0, 1'b0, 2'(id), 1'b0, 1'b1, exp_rd));
        end

        for (int i = 0; i < vecs.size(); i++) begin
            v       = vecs[i];
            preset  = v.rst;
            req     = v.req;
            m_ready = v.rdy;
            m_rdata = v.mrd;
            step();
            check_row($sformatf("row%0d", i), v);
        end

        // Command freeze: requester 1 changes its address mid-WAIT while 3 waits.
        preset  = 1'b0;
        req     = 4'b1010;
        m_ready = 1'b0;
        m_rdata = '0;
        step();
        check("freeze.gnt", 32'(gnt_id), 32'd1);
        check("freeze.addr_issue", m_addr, 32'h0000_0100);
        step();
        check("freeze.xfer", 32'(m_transfer), 32'd1);
        a_addr[1] = 32'hBAD0_0000;
        step();
        step();
        check("freeze.addr_wait", m_addr, 32'h0000_0100);
        check("freeze.still_wait", 32'(m_transfer), 32'd1);
        m_ready = 1'b1;
        m_rdata = 32'h5555_5555;
        step();
        check("freeze.done", 32'(done), 32'h2);
        check("freeze.rdata", rdata, 32'h5555_5555);
        check("freeze.addr_done", m_addr, 32'h0000_0100);
        req       = 4'b1000;
        m_ready   = 1'b0;
        a_addr[1] = C_ADDR[1];
        step();
        check("freeze.idle_busy", 32'(busy), 32'd0);
        step();
        check("freeze.next_gnt", 32'(gnt_id), 32'd3);
        check("freeze.next_addr", m_addr, 32'h0000_0300);
        step();
        m_ready = 1'b1;
        m_rdata = 32'h6666_6666;
        step();
        check("freeze.done3", 32'(done), 32'h8);
        check("freeze.rdata3", rdata, 32'h6666_6666);
        req     = 4'b0000;
        m_ready = 1'b0;
        step();

        // Reset during WAIT, then all request: requester 0 must win.
        req = 4'b0100;
        step();
        step();
        check("rstwait.xfer_before", 32'(m_transfer), 32'd1);
        preset = 1'b1;
        step();
        check("rstwait.xfer", 32'(m_transfer), 32'd0);
        check("rstwait.done", 32'(done), 32'd0);
        check("rstwait.busy", 32'(busy), 32'd0);
        check("rstwait.gnt", 32'(gnt_id), 32'd0);
        preset = 1'b0;
        req    = 4'b1111;
        step();
        check("rstwait.prio_gnt", 32'(gnt_id), 32'd0);
        check("rstwait.prio_busy", 32'(busy), 32'd1);
        // Request dropped after grant: the transfer still completes.
        req = 4'b0000;
        step();
        check("rstwait.xfer_after", 32'(m_transfer), 32'd1);
        m_ready = 1'b1;
        m_rdata = 32'h7777_7777;
        step();
        check("rstwait.done_after", 32'(done), 32'h1);
        check("rstwait.rdata_after", rdata, 32'h7777_7777);
        m_ready = 1'b0;
        step();
        check("rstwait.done_clear", 32'(done), 32'd0);

`ifdef APB_ARB_TIMEOUT_EN
        // Timeout after 8 WAIT cycles with READY low.
        req = 4'b0010;
        step();
        step();
        for (int c = 0; c < 7; c++) begin
            check($sformatf("timeout.wait%0d", c), 32'(m_transfer), 32'd1);
            step();
        end
        check("timeout.wait_last", 32'(done), 32'd0);
        step();
        check("timeout.done", 32'(done), 32'h2);
        check("timeout.err", 32'(err), 32'h2);
        check("timeout.rdata", rdata, 32'h0);
        check("timeout.xfer", 32'(m_transfer), 32'd0);
        req = 4'b0000;
        step();
        check("timeout.err_clear", 32'(err), 32'd0);
        // READY on the timeout edge wins.
        req = 4'b0010;
        step();
        step();
        for (int c = 0; c < 7; c++) step();
        m_ready = 1'b1;
        m_rdata = 32'h8888_8888;
        step();
        check("race.done", 32'(done), 32'h2);
        check("race.err", 32'(err), 32'd0);
        check("race.rdata", rdata, 32'h8888_8888);
        req     = 4'b0000;
        m_ready = 1'b0;
        step();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/apb_req_arbiter.md
Name: apb_req_arbiter

Overview:
- Shares the single APB master's higher-logic command port between NUM_REQ independent requesters (CPU shim, DMA, test port, ...).
- Sits between the requesters and the master's transfer/ADDR/WDATA/STRB/WRITE/READY/RDATA interface.
- Round-robin, one APB transaction per grant.
- Latches the winner's command, drives the master until READY, returns read data with a one-cycle done pulse.

Parameters:
- DATA_WIDTH, 32, data bus width; STRB width = DATA_WIDTH/8.
- MAIN_ADDR_WIDTH, 32, address width.
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT_CYCLES, 255, watchdog limit. Used only with APB_ARB_TIMEOUT_EN.

Ports:
- PCLK  in  1  clock.
- PRESET  in  1  reset; synchronous, active-high.
- REQ  in  NUM_REQ  per-requester request level.
- REQ_ADDR  in  NUM_REQ*MAIN_ADDR_WIDTH  flattened addresses; requester i at slice i.
- REQ_WDATA  in  NUM_REQ*DATA_WIDTH  flattened write data.
- REQ_STRB  in  NUM_REQ*(DATA_WIDTH/8)  flattened byte strobes.
- REQ_WRITE  in  NUM_REQ  1 = write, 0 = read.
- DONE  out  NUM_REQ  one-hot, one-cycle completion pulse.
- RDATA  out  DATA_WIDTH  read data of the last completed transfer.
- GNT_ID  out  clog2(NUM_REQ)  index of the current or last grantee.
- BUSY  out  1  high from grant until DONE.
- M_TRANSFER  out  1  to the master's transfer input.
- M_ADDR  out  MAIN_ADDR_WIDTH  to master ADDR.
- M_WDATA  out  DATA_WIDTH  to master WDATA.
- M_STRB  out  DATA_WIDTH/8  to master STRB.
- M_WRITE  out  1  to master WRITE.
- M_READY  in  1  master READY; completion of the access phase.
- M_RDATA  in  DATA_WIDTH  master RDATA; valid when M_READY = 1.
- ERR  out  NUM_REQ  timeout flag, aligned with DONE. Present only with APB_ARB_TIMEOUT_EN.

Behaviour:
- Reset values (PRESET sampled high at a PCLK edge, in any state): state IDLE; all outputs 0; round-robin pointer = NUM_REQ-1, so requester 0 has top priority first.
- Requester rule: raise REQ[i] with its command stable; keep both unchanged until DONE[i]. In the cycle after DONE[i], REQ[i] is low or carries a new command.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If REQ is nonzero, select the first set bit searching ptr+1, ptr+2, ... modulo NUM_REQ.
  - Register the winner's ADDR/WDATA/STRB/WRITE onto M_* outputs and its index onto GNT_ID.
  - Set ptr = winner, set BUSY = 1, go to ISSUE. Grant latency is 1 cycle from REQ sampled.
- ISSUE:
  - Drive M_TRANSFER = 1, go to WAIT.
  - M_* outputs stay frozen from grant to DONE; requester input changes are ignored.
- WAIT:
  - Hold M_TRANSFER = 1 until M_READY = 1.
  - On that edge: capture M_RDATA into RDATA (reads only; writes leave RDATA unchanged), clear M_TRANSFER, go to DONE.
- DONE:
  - Assert DONE[GNT_ID] for exactly one cycle, clear BUSY, return to IDLE.
  - Minimum request-to-DONE time is 4 cycles plus the master's SETUP/ACCESS latency.
- Simultaneous requests: strict round-robin. With all REQ held, grant order is 0,1,2,3,0,...
- Single requester: that requester is re-granted back-to-back with no starvation penalty.
- Requests arriving while not in IDLE wait; no request is dropped.
- REQ deasserted before grant: not granted. REQ deasserted after grant: the transfer still completes and DONE still pulses.
- M_READY outside WAIT is ignored.
- Reset mid-transfer: M_TRANSFER drops the same cycle and no DONE is issued; the master is reset by the same reset.

Optional Feature:
- Macro: APB_ARB_TIMEOUT_EN.
- Defined:
  - An 8..16-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES without M_READY: drop M_TRANSFER, set RDATA = 0, go to DONE, and pulse ERR[GNT_ID] together with DONE[GNT_ID].
  - M_READY arriving on the same edge as the timeout wins: normal completion, no ERR.
- Not defined: no counter and no ERR port; WAIT lasts indefinitely.

Test Plan:
- Reset then single read:
  - Stimulus: REQ = 0001, addr 0x0000_0004; master returns RDATA 0xDEAD_BEEF with M_READY.
  - Response: DONE = 0001 for one cycle, RDATA = 0xDEAD_BEEF, GNT_ID = 0, M_WRITE = 0.
- Fairness:
  - Stimulus: REQ = 1111 held, each requester re-requesting after its DONE.
  - Response: DONE order 0001, 0010, 0100, 1000, 0001; BUSY low exactly 1 cycle between grants.
- Write pass-through:
  - Stimulus: requester 2 writes addr 0x10, data 0x1234_5678, STRB 0101.
  - Response: M_* carries exactly those values from ISSUE to DONE; RDATA unchanged.
- Command freeze:
  - Stimulus: requester 1 changes REQ_ADDR during WAIT, with requester 3 also requesting.
  - Response: M_ADDR stays at the granted value; requester 3 is granted next, in the IDLE cycle after DONE.
- Reset mid-WAIT:
  - Stimulus: assert PRESET for 1 cycle during WAIT.
  - Response: next cycle M_TRANSFER = 0, DONE = 0, BUSY = 0, GNT_ID = 0; requester 0 has priority.
- Timeout (APB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 8):
  - Stimulus: M_READY held low.
  - Response: after 8 WAIT cycles, DONE[i] = ERR[i] = 1 and RDATA = 0.
